// File: rtl/paddle_bank.sv
// paddle_bank: NUM_PADDLES independent paddle trackers with tick pacing,
// stepwise acceleration and clamp/wrap at the playfield limits.
module paddle_bank #(
  parameter int NUM_PADDLES = 2,
  parameter int POS_W       = 10,
  parameter int Y_RES       = 480,
  parameter int PADDLE_H    = 64,
  parameter int TICK_W      = 16,
  parameter int ACCEL_MOVES = 4,
  parameter int MAX_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         game_on,
  input  logic                         wrap_mode,
  input  logic                         recenter,
  input  logic [NUM_PADDLES-1:0]       up,
  input  logic [NUM_PADDLES-1:0]       down,
  input  logic [TICK_W-1:0]            ticks_per_px,
  output logic [NUM_PADDLES*POS_W-1:0] position,
  output logic [NUM_PADDLES-1:0]       moving_up,
  output logic [NUM_PADDLES-1:0]       moving_down,
  output logic [NUM_PADDLES-1:0]       edge_hit
);

  localparam int SW = POS_W + 2;
  localparam int LW = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1;
  localparam int CW = $clog2(ACCEL_MOVES + 1);
  localparam int PMIN = PADDLE_H / 2;
  localparam int PMAX = Y_RES - 1 - PADDLE_H / 2;
  localparam int CTR  = Y_RES / 2;

  localparam logic signed [SW-1:0] L_MIN = SW'(PMIN);
  localparam logic signed [SW-1:0] L_MAX = SW'(PMAX);
  localparam logic [POS_W-1:0] P_MIN = POS_W'(PMIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(PMAX);
  localparam logic [POS_W-1:0] P_CTR = POS_W'(CTR);
  localparam logic [LW-1:0] L_TOP = LW'(MAX_LEVEL);
  localparam logic [CW-1:0] C_LAST = CW'(ACCEL_MOVES - 1);
  localparam logic [CW-1:0] C_SAT = CW'(ACCEL_MOVES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN
  } st_t;

  // tpp-1 with a zero setting behaving as one clock per move
  logic [TICK_W-1:0] w_tpp_m1;
  assign w_tpp_m1 = (ticks_per_px == '0) ? '0
                  : ticks_per_px - TICK_W'(1);

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
    st_t                r_state, w_state, w_req;
    logic [POS_W-1:0]   r_pos, w_pos;
    logic [TICK_W-1:0]  r_ticks, w_ticks;
    logic [LW-1:0]      r_lvl, w_lvl;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic               r_edge, w_edge;
    logic signed [SW-1:0] w_step, w_cur, w_cand;

    always_comb begin
      w_req = S_IDLE;
      unique case (1'b1)
        (up[g] && !down[g]): w_req = S_UP;
        (down[g] && !up[g]): w_req = S_DOWN;
        default:             w_req = S_IDLE;
      endcase
    end

    assign w_step = SW'(1) << r_lvl;
    assign w_cur  = $signed({2'b00, r_pos});
    assign w_cand = (r_state == S_UP) ? w_cur - w_step
                                      : w_cur + w_step;

    always_comb begin
      w_state = r_state;
      w_pos   = r_pos;
      w_ticks = r_ticks;
      w_lvl   = r_lvl;
      w_cnt   = r_cnt;
      w_edge  = 1'b0;
      if (recenter) begin
        w_state = S_IDLE;
        w_pos   = P_CTR;
        w_ticks = '0;
        w_lvl   = '0;
        w_cnt   = '0;
      end else if (!game_on) begin
        w_state = S_IDLE;
        w_ticks = '0;
        w_lvl   = '0;
        w_cnt   = '0;
      end else if (w_req != r_state) begin
        w_state = w_req;
        w_ticks = '0;
        w_lvl   = '0;
        w_cnt   = '0;
      end else if (r_state != S_IDLE) begin
        if (r_ticks >= w_tpp_m1) begin
          w_ticks = '0;
          if (w_cand < L_MIN) begin
            w_pos  = wrap_mode ? P_MAX : P_MIN;
            w_edge = 1'b1;
          end else if (w_cand > L_MAX) begin
            w_pos  = wrap_mode ? P_MIN : P_MAX;
            w_edge = 1'b1;
          end else begin
            w_pos = w_cand[POS_W-1:0];
          end
          // at the top level the counter just saturates
          if (r_lvl < L_TOP && r_cnt == C_LAST) begin
            w_lvl = r_lvl + LW'(1);
            w_cnt = '0;
          end else if (r_cnt < C_SAT) begin
            w_cnt = r_cnt + CW'(1);
          end
        end else begin
          w_ticks = r_ticks + TICK_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_pos   <= P_CTR;
        r_ticks <= '0;
        r_lvl   <= '0;
        r_cnt   <= '0;
        r_edge  <= 1'b0;
      end else begin
        r_state <= w_state;
        r_pos   <= w_pos;
        r_ticks <= w_ticks;
        r_lvl   <= w_lvl;
        r_cnt   <= w_cnt;
        r_edge  <= w_edge;
      end
    end

    assign position[g*POS_W +: POS_W] = r_pos;
    assign moving_up[g]   = (r_state == S_UP);
    assign moving_down[g] = (r_state == S_DOWN);
    assign edge_hit[g]    = r_edge;
  end

endmodule

// File: doc/paddle_bank.md
Name: paddle_bank

Overview:
- Parametrised multi-channel successor to the single paddle tracker. Keeps NUM_PADDLES independent paddle centre positions, with sub-pixel tick pacing, stepwise acceleration and height-aware clamp or wrap at the playfield limits.
- Sits between the debounced player-input logic and the renderer/collision logic. Publishes each paddle's centre row, its motion flags and an edge-hit pulse.

Parameters:
- NUM_PADDLES, 2, number of independent paddle channels.
- POS_W, 10, position width in bits, unsigned; must satisfy 2^POS_W > Y_RES.
- Y_RES, 480, playfield height in rows.
- PADDLE_H, 64, paddle height in rows.
- TICK_W, 16, width of ticks_per_px and of each channel's tick counter.
- ACCEL_MOVES, 4, number of moves completed at one speed level before stepping to the next level.
- MAX_LEVEL, 2, highest speed level. Step size is 1<<level, so the maximum step is 4 px.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- game_on  in  1  motion enable.
- wrap_mode  in  1  1 = wrap at limits, 0 = clamp at limits.
- recenter  in  1  synchronous recenter of all channels.
- up  in  NUM_PADDLES  per-channel up request; up decreases position.
- down  in  NUM_PADDLES  per-channel down request; down increases position.
- ticks_per_px  in  TICK_W  clocks per move, shared by all channels; the value 0 is treated as 1.
- position  out  NUM_PADDLES*POS_W  packed centre rows; channel i occupies bits [i*POS_W +: POS_W].
- moving_up  out  NUM_PADDLES  channel is in state UP.
- moving_down  out  NUM_PADDLES  channel is in state DOWN.
- edge_hit  out  NUM_PADDLES  one-cycle pulse on a clamp or wrap event.

Behaviour:
- Derived constants:
  - PMIN = PADDLE_H/2
  - PMAX = Y_RES-1-PADDLE_H/2
  - CTR = Y_RES/2
  - With the defaults: 32, 447, 240.
- Reset (async, reset=0):
  - Every position = CTR.
  - Every state = IDLE; ticks = 0, level = 0, move counter = 0.
  - moving_up, moving_down and edge_hit all 0.
- Priority at each edge, after reset: recenter, then game_on, then channel FSM.
  - recenter=1: all channels take their reset values (except reset itself is not asserted).
  - game_on=0: positions hold; each FSM is forced to IDLE; counters cleared; flags 0.
- Per-channel FSM, states IDLE, UP, DOWN, with req = {up[i], down[i]}:
  - req 10 requests UP; req 01 requests DOWN; req 00 or 11 forces IDLE.
- Entering a state (from IDLE or on a reversal):
  - That edge moves nothing.
  - ticks, level and the move counter are set to 0.
- Staying in UP or DOWN, with tpp = max(ticks_per_px, 1):
  - If ticks == tpp-1: perform a move and set ticks to 0.
  - Otherwise: ticks increments.
  - Result: first move lands tpp edges after the entry edge, then one move every tpp edges.
- Move step = 1<<level. After each move:
  - The move counter increments.
  - When it reaches ACCEL_MOVES and level < MAX_LEVEL: level increments and the move counter clears.
  - At MAX_LEVEL the counter saturates and the level is not changed.
- Move arithmetic:
  - Candidate position is computed in POS_W+2 bits, signed: position ∓ step.
  - Candidate within [PMIN, PMAX]: accept it; edge_hit stays 0.
  - Candidate < PMIN: clamp mode gives PMIN, wrap mode gives PMAX; edge_hit=1 for one cycle.
  - Candidate > PMAX: clamp mode gives PMAX, wrap mode gives PMIN; edge_hit=1 for one cycle.
  - A clamped paddle sitting at its limit pulses edge_hit on every further move attempt.
- Flags:
  - moving_up is registered and equals (state==UP); moving_down equals (state==DOWN).
  - The two are never both 1.
  - edge_hit is 0 on every cycle without a limit event.
- Channels are fully independent, apart from the shared ticks_per_px, wrap_mode, game_on and recenter.
- A change of ticks_per_px takes effect on the next comparison.
  - If ticks is already at or above the new tpp-1, the move happens on the next edge.

Test Plan:
1. Reset with defaults -> position = {240,240}; moving_up, moving_down and edge_hit all 0.
2. tpp=4, hold up[0] from edge 0 -> position[0] = 239, 238, 237, 236 at edges 4, 8, 12, 16, then 234 at edge 20 and 232 at edge 24 (level 1). Reaches 4-px steps after 4 more moves. Channel 1 holds 240 throughout.
3. Clamp: channel at 33, level 1, wrap_mode=0, up -> next move gives 32 with a one-cycle edge_hit. Each further move stays at 32 and pulses edge_hit again.
4. Wrap: channel at 32, wrap_mode=1, up, level 0 -> next move gives 447 with edge_hit. Mirror case: 447 with down gives 32.
5. Release, both-pressed and game_on:
   - up and down both 1 -> IDLE, flags 0, no movement.
   - Reversal up→down mid-count -> no move on the reversal edge; first down move comes tpp edges later, with step 1.
   - game_on drops mid-count -> position holds; on re-enable a full tpp count restarts.
6. Reset and recenter mid-motion:
   - Async reset=0 between edges -> positions 240 and flags 0 immediately.
   - recenter pulse -> all positions 240 on the next edge, regardless of up/down.
